serial_frame_rx: RTL and testbench

Downstream consumer of the registered data bit produced by the D flip-flop stage. It samples the `q` stream one bit per qualified clock and frames it as start bit, DATA_W data bits (LSB first), optional even-parity bit and stop bit. It then presents the assembled word with a single-cycle valid pulse, plus single-cycle parity and framing error flags. It sits between the bit-capture flop and any word-level logic.

---
 rtl/serial_frame_pkg.sv | 15 +
 rtl/rx_shift_reg.sv | 45 ++++
 rtl/serial_frame_rx.sv | 126 ++++++++++++
 tb/tb_serial_frame_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared state type and line-level constants for the serial frame receiver
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/rx_shift_reg.sv
// rtl/rx_shift_reg.sv - LSB-first indexed shift register with running XOR parity accumulator
module rx_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      shift_en_i,
  input  logic                      par_en_i,
  input  logic                      bit_i,
  input  logic [$clog2(DATA_W)-1:0] idx_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      acc_o
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic              acc_q, acc_d;

  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    if (clr_i) begin
      shift_d = '0;
      acc_d   = 1'b0;
    end else begin
      if (shift_en_i) shift_d[idx_i] = bit_i;
      // Data and parity bits both fold into the accumulator; only data bits land in the word.
      if (shift_en_i || par_en_i) acc_d = acc_q ^ bit_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      acc_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
    end
  end

  assign data_o = shift_q;
  assign acc_o  = acc_q;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - frames a qualified serial bit stream into words with parity/framing checks
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;

  logic              clr, shift_en, par_en;
  logic [DATA_W-1:0] shift_data;
  logic              acc;
  logic              parity_ok;

  rx_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .shift_en_i (shift_en),
    .par_en_i   (par_en),
    .bit_i      (bit_in),
    .idx_i      (cnt_q),
    .data_o     (shift_data),
    .acc_o      (acc)
  );

  // Without a parity bit every correctly stopped frame is accepted.
  assign parity_ok = !PARITY_EN || !acc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    clr      = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (bit_in == LINE_START) begin
            state_d = DATA;
            cnt_d   = '0;
            clr     = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (PARITY_EN) state_d = PARITY;
            else           state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_en  = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          // A bad stop bit is never reinterpreted as the next start bit.
          state_d = IDLE;
          if (bit_in != LINE_STOP) begin
            ferr_d = 1'b1;
          end else if (parity_ok) begin
            valid_d = 1'b1;
            data_d  = shift_data;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - randomized scoreboard bench for serial_frame_rx (parity and no-parity builds)
module tb_serial_frame_rx;

  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_en, bit_in2, bit_en2;
  logic [7:0] data_out, data_out2;
  logic       data_valid, parity_err, frame_err, busy;
  logic       data_valid2, parity_err2, frame_err2, busy2;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t        act_q[$];
  ev_t        exp_q[$];
  bit         exp_busy[MAXC];
  bit         act_busy[MAXC];
  logic [7:0] last_good = 8'h00;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst), .bit_in(bit_in2), .bit_en(bit_en2),
    .data_out(data_out2), .data_valid(data_valid2), .parity_err(parity_err2),
    .frame_err(frame_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < MAXC) act_busy[cyc] <= busy;
    if (data_valid || parity_err || frame_err)
      act_q.push_back('{cyc, {data_valid, parity_err, frame_err}, data_out});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic b, input logic en, output int edge_o);
    @(negedge clk);
    bit_in = b;
    bit_en = en;
    edge_o = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) put(1'b0, 1'b1, e);
  endtask

  // mode 0: no gaps, 1: bit_en alternating, 2: random gaps carrying junk bits
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int mode);
    logic bits[$];
    int   e, s_edge, p_edge;
    bit   ok;
    bits.push_back(1'b1);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    bits.push_back(par);
    bits.push_back(stop);
    s_edge = 0;
    e = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if (mode == 1 && i > 0) put(1'($urandom), 1'b0, e);
      else if (mode == 2) repeat ($urandom_range(0, 2)) put(1'($urandom), 1'b0, e);
      put(bits[i], 1'b1, e);
      if (i == 0) s_edge = e;
    end
    p_edge = e;
    for (int c = s_edge; c < p_edge && c < MAXC; c++) exp_busy[c] = 1'b1;
    ok = ((^d) ^ par) == 1'b0;
    if (stop) begin
      exp_q.push_back('{p_edge, 3'b001, last_good});
    end else if (ok) begin
      last_good = d;
      exp_q.push_back('{p_edge, 3'b100, d});
    end else begin
      exp_q.push_back('{p_edge, 3'b010, last_good});
    end
  endtask

  task automatic np_frame(input logic [7:0] d, input logic stop, output int lat,
                          output logic [2:0] kind, output logic [7:0] dout);
    logic bits[$];
    int   s;
    bits.push_back(1'b1);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    bits.push_back(stop);
    s = 0;
    for (int i = 0; i < bits.size(); i++) begin
      @(negedge clk);
      bit_in2 = bits[i];
      bit_en2 = 1'b1;
      if (i == 0) s = cyc + 1;
    end
    lat  = -1;
    kind = 3'b000;
    dout = 8'h00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bit_in2 = 1'b0;
      bit_en2 = 1'b1;
      if (lat < 0 && (data_valid2 || parity_err2 || frame_err2)) begin
        lat  = cyc - s;
        kind = {data_valid2, parity_err2, frame_err2};
        dout = data_out2;
      end
    end
  endtask

  initial begin
    int         e, s, mism, nlat;
    logic [2:0] nkind;
    logic [7:0] nd, rd;
    logic       rp, rs;

    rst = 1'b0;
    bit_in = 1'b0;
    bit_en = 1'b0;
    bit_in2 = 1'b0;
    bit_en2 = 1'b0;
    #10;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    #2 rst = 1'b1;

    idle(3);
    repeat (2) put(1'b1, 1'b0, e);
    idle(2);

    send_frame(8'hA5, 1'b0, 1'b0, 0);
    idle(2);
    send_frame(8'h01, 1'b0, 1'b0, 0);
    idle(2);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle(5);
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 1'b0, 1'b0, 0);
    idle(2);

    put(1'b1, 1'b1, s);
    repeat (4) put(1'($urandom), 1'b1, e);
    @(negedge clk);
    for (int c = s; c <= s + 4; c++) exp_busy[c] = 1'b1;
    #2 rst = 1'b0;
    bit_en = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", data_valid, 1'b0);
    last_good = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    idle(4);

    for (int f = 0; f < 40; f++) begin
      rd = 8'($urandom);
      rp = (^rd) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 6) == 0);
      send_frame(rd, rp, rs, $urandom_range(0, 1) * 2);
      idle($urandom_range(0, 3));
    end
    idle(4);

    chk("ev_count", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk("ev_cyc", act_q[i].cyc, exp_q[i].cyc);
      chk("ev_kind", act_q[i].kind, exp_q[i].kind);
      chk("ev_data", act_q[i].data, exp_q[i].data);
    end
    mism = 0;
    for (int c = 0; c < cyc && c < MAXC; c++)
      if (exp_busy[c] != act_busy[c]) mism++;
    chk("busy_trace", mism, 0);
    chk("final_data_out", data_out, last_good);

    np_frame(8'hFF, 1'b0, nlat, nkind, nd);
    chk("np_lat", nlat, 9);
    chk("np_kind", nkind, 3'b100);
    chk("np_data", nd, 8'hFF);
    np_frame(8'h5A, 1'b1, nlat, nkind, nd);
    chk("np_ferr_kind", nkind, 3'b001);
    chk("np_ferr_data", nd, 8'hFF);
    np_frame(8'h01, 1'b0, nlat, nkind, nd);
    chk("np_odd_kind", nkind, 3'b100);
    chk("np_odd_data", nd, 8'h01);
    chk("np_busy_end", busy2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
